// File: rtl/logic_unit_pipe_pkg.sv
// Shared opcode definitions and helpers for the registered logic unit.
// Latency: n/a (definitions only).
// Backpressure: n/a.
`ifndef LOGIC_UNIT_DEFS_VH
`define LOGIC_UNIT_DEFS_VH
`define LU_OP_W 3
`define LU_AND  3'b000
`define LU_OR   3'b001
`define LU_XOR  3'b010
`define LU_NOR  3'b011
`define LU_XNOR 3'b100
`define LU_NAND 3'b101
`define LU_ANDN 3'b110
`define LU_XACC 3'b111
`endif

package logic_unit_pipe_pkg;

    localparam int LU_OP_W = `LU_OP_W;

    typedef enum logic [LU_OP_W-1:0] {
        OP_AND  = `LU_AND,
        OP_OR   = `LU_OR,
        OP_XOR  = `LU_XOR,
        OP_NOR  = `LU_NOR,
        OP_XNOR = `LU_XNOR,
        OP_NAND = `LU_NAND,
        OP_ANDN = `LU_ANDN,
        OP_XACC = `LU_XACC
    } lu_op_e;

endpackage

// File: rtl/logic_unit_pipe_core.sv
// Combinational bitwise op select: (op, a, b, acc_base) -> result.
// Latency: 0 cycles, no state.
// Backpressure: none; the caller decides when the result is captured.
module logic_unit_core
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [LU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   acc_base,
    output logic [WIDTH-1:0]   result
);

    // Pure bitwise select; XACC folds both operands into the accumulator base.
    always_comb begin
        result = '0;
        case (op)
            `LU_AND:  result = a & b;
            `LU_OR:   result = a | b;
            `LU_XOR:  result = a ^ b;
            `LU_NOR:  result = ~(a | b);
            `LU_XNOR: result = ~(a ^ b);
            `LU_NAND: result = ~(a & b);
            `LU_ANDN: result = a & ~b;
            `LU_XACC: result = acc_base ^ a ^ b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit with zero/parity flags and optional XOR accumulator.
// Latency: 1 cycle from accepted beat to out/out_valid; 1 beat/cycle throughput.
// Backpressure: in_ready = ~out_valid | out_ready; a stalled result holds stable.
module logic_unit_pipe
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit ACC_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out,
    output logic               zero,
    output logic               parity
);

    logic             accept;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] result;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .op       (op),
        .a        (a),
        .b        (b),
        .acc_base (acc_base),
        .result   (result)
    );

    generate
        if (ACC_EN) begin : g_acc
            logic [WIDTH-1:0] acc;

            // A clear in the same cycle as an XACC makes that beat start from zero.
            assign acc_base = acc_clr ? '0 : acc;

            // Accumulator updates only on an accepted XACC or on a clear.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc <= '0;
                end else if (accept && (op == `LU_XACC)) begin
                    acc <= result;
                end else if (acc_clr) begin
                    acc <= '0;
                end
            end
        end else begin : g_noacc
            // Without the accumulator XACC degenerates to a plain XOR.
            assign acc_base = '0;
        end
    endgenerate

    // Output register: load on accept, drop valid on drain, hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            zero      <= 1'b1;
            parity    <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out       <= result;
            zero      <= (result == '0);
            parity    <= ^result;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        acc_clr = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready0, out_valid0, zero0, parity0;
    logic [31:0] out0;
    logic        in_ready1, out_valid1, zero1, parity1;
    logic [31:0] out1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(32), .ACC_EN(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .op(op), .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid0),
        .out_ready(out_ready), .out(out0), .zero(zero0), .parity(parity0)
    );

    logic_unit_pipe #(.WIDTH(32), .ACC_EN(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .op(op), .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid1),
        .out_ready(out_ready), .out(out1), .zero(zero1), .parity(parity1)
    );

    typedef struct {
        logic        clr;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_res(input string nm, input logic [31:0] exp);
        chk({nm, ".out"}, out0, exp);
        chk({nm, ".valid"}, {31'b0, out_valid0}, 32'd1);
        chk({nm, ".zero"}, {31'b0, zero0}, {31'b0, (exp == 32'd0)});
        chk({nm, ".parity"}, {31'b0, parity0}, {31'b0, ^exp});
    endtask

    // Drive one beat, advance one edge, sample 1 time unit after it.
    task automatic beat(input logic clr, input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
        in_valid = 1'b1; acc_clr = clr; op = o; a = va; b = vb;
        @(posedge clk); #1;
        in_valid = 1'b0; acc_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 3'b000, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h00F0_0034};
        vecs[1]  = '{1'b0, 3'b001, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFFF0_12FF};
        vecs[2]  = '{1'b0, 3'b010, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFF00_12CB};
        vecs[3]  = '{1'b0, 3'b011, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h000F_ED00};
        vecs[4]  = '{1'b0, 3'b100, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h00FF_ED34};
        vecs[5]  = '{1'b0, 3'b101, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFF0F_FFCB};
        vecs[6]  = '{1'b0, 3'b110, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hF000_1200};
        vecs[7]  = '{1'b0, 3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[8]  = '{1'b1, 3'b111, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001};
        vecs[9]  = '{1'b0, 3'b111, 32'h0000_0002, 32'h0000_0000, 32'h0000_0003};
        vecs[10] = '{1'b0, 3'b111, 32'h0000_0004, 32'h0000_0000, 32'h0000_0007};
        vecs[11] = '{1'b1, 3'b111, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[12] = '{1'b1, 3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005};
        vecs[13] = '{1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_FFFF};
        vecs[14] = '{1'b0, 3'b111, 32'h0000_0000, 32'h0000_0000, 32'h0000_0005};

        // Reset state while rst_n is held low.
        #12;
        chk("rst.valid", {31'b0, out_valid0}, 32'd0);
        chk("rst.out", out0, 32'd0);
        chk("rst.zero", {31'b0, zero0}, 32'd1);
        chk("rst.parity", {31'b0, parity0}, 32'd0);
        chk("rst.in_ready", {31'b0, in_ready0}, 32'd1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back vectors: each result visible exactly one edge after its beat.
        in_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            acc_clr = vecs[i].clr; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
            @(posedge clk); #1;
            chk_res($sformatf("vec%0d", i), vecs[i].exp);
        end
        in_valid = 1'b0; acc_clr = 1'b0;

        // Clear with no beat: result drains, out unchanged, acc zeroed.
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        chk("clr_only.valid", {31'b0, out_valid0}, 32'd0);
        chk("clr_only.out", out0, 32'h0000_0005);
        beat(1'b0, 3'b111, 32'h0000_0008, 32'h0000_0000);
        chk_res("clr_only.acc", 32'h0000_0008);

        // Backpressure: hold result A for 3 cycles, then drain+accept B with no bubble.
        beat(1'b0, 3'b001, 32'h0000_00A0, 32'h0000_000A);
        chk_res("bp.A", 32'h0000_00AA);
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'b000; a = 32'h0000_0F0F; b = 32'h0000_00FF;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp.hold%0d.out", k), out0, 32'h0000_00AA);
            chk($sformatf("bp.hold%0d.in_ready", k), {31'b0, in_ready0}, 32'd0);
            chk($sformatf("bp.hold%0d.valid", k), {31'b0, out_valid0}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release.in_ready", {31'b0, in_ready0}, 32'd1);
        @(posedge clk); #1;
        chk_res("bp.B", 32'h0000_000F);
        op = 3'b110; a = 32'h0000_00FF; b = 32'h0000_000F;
        @(posedge clk); #1;
        chk_res("bp.C", 32'h0000_00F0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp.drain.valid", {31'b0, out_valid0}, 32'd0);

        // Reset asserted mid-stall: output and acc cleared asynchronously.
        beat(1'b0, 3'b111, 32'h0000_0009, 32'h0000_0000);
        chk_res("mid.pre", 32'h0000_0001);
        out_ready = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid.rst.valid", {31'b0, out_valid0}, 32'd0);
        chk("mid.rst.out", out0, 32'd0);
        chk("mid.rst.zero", {31'b0, zero0}, 32'd1);
        out_ready = 1'b1;
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        beat(1'b0, 3'b111, 32'h0000_0000, 32'h0000_0000);
        chk_res("mid.post.acc", 32'h0000_0000);

        // Accumulator removed: XACC acts as XOR and never accumulates.
        beat(1'b0, 3'b111, 32'h0000_0003, 32'h0000_0001);
        chk("noacc1.out", out1, 32'h0000_0002);
        chk_res("acc1", 32'h0000_0002);
        beat(1'b0, 3'b111, 32'h0000_0003, 32'h0000_0001);
        chk("noacc2.out", out1, 32'h0000_0002);
        chk_res("acc2", 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
